// File: rtl/rv_loader_pkg.sv
// Shared types and framing constants for the UART program loader.
// Imported by the byte fetcher and the loader top.
package rv_loader_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SYNC,
        LEN0,
        LEN1,
        DATA,
        WRITE,
        CSUM,
        ACK,
        DONE
    } loader_state_t;

    localparam logic [7:0] LOADER_SYNC = 8'hA5;
    localparam logic [7:0] LOADER_ACK  = 8'h06;
    localparam logic [7:0] LOADER_NAK  = 8'h15;

    // States that consume a byte from the RX FIFO
    function automatic logic wants_byte(input loader_state_t s);
        return (s == SYNC) || (s == LEN0) || (s == LEN1) || (s == DATA) || (s == CSUM);
    endfunction

    // States covered by the inter-byte timeout (SYNC may wait forever)
    function automatic logic timed_state(input loader_state_t s);
        return (s == LEN0) || (s == LEN1) || (s == DATA) || (s == WRITE) || (s == CSUM);
    endfunction

endpackage

// File: rtl/loader_byte_fetch.sv
// RX FIFO pop pacing, byte hand-off and inter-byte timeout for the program loader.
// Pops are never back-to-back, so the FIFO head has a full cycle to update.
module loader_byte_fetch
    import rv_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       Rst,
    input  logic       want,
    input  logic       rx_data_present,
    input  logic [7:0] uart_dout,
    input  logic       tmr_clr,
    input  logic       tmr_run,
    output logic       rx_ren,
    output logic       byte_vld,
    output logic [7:0] byte_data,
    output logic       timeout
);

    localparam int             CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  TLIM = CW'(TIMEOUT_CYCLES - 1);

    logic          ren_q;
    logic [CW-1:0] cnt_q;

    assign rx_ren    = want && rx_data_present && !ren_q;
    assign byte_vld  = rx_ren;
    assign byte_data = uart_dout;

    // cnt_q counts cycles since the last pop, the pop cycle itself being 1;
    // the FSM leaves on the edge at which the count reaches TIMEOUT_CYCLES.
    assign timeout = tmr_run && (cnt_q >= TLIM);

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            ren_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            ren_q <= rx_ren;
            if (tmr_clr)
                cnt_q <= '0;
            else if (rx_ren)
                cnt_q <= CW'(1);
            else if (tmr_run && (cnt_q < TLIM))
                cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// Framed UART-to-instruction-memory loader: sync, 16-bit word count, LE words, XOR checksum,
// answered with ACK/NAK. Writes already issued are kept even when the frame is rejected.
module uart_prog_loader
    import rv_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          MAX_WORDS      = 4096,
    parameter int          TIMEOUT_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        prog,
    input  logic [7:0]  uart_dout,
    input  logic        rx_data_present,
    output logic        rx_ren,
    input  logic        tx_full,
    output logic        tx_wen,
    output logic [7:0]  uart_din,
    output logic        imem_prog_ena,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_din,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    loader_state_t state_q, state_d;
    logic          prog_q;
    logic          done_q, done_d, err_q, err_d;
    logic [7:0]    code_q, code_d;
    logic [15:0]   widx_q, n_q, n_rx;
    logic [1:0]    bc_q;
    logic [7:0]    len_lo_q, xor_q;
    logic [31:0]   word_q;
    logic          sess_clr, word_last, accept, reject;
    logic          want, tmr_run, byte_vld, timeout;
    logic [7:0]    byte_data;

    assign want    = prog && wants_byte(state_q);
    assign tmr_run = timed_state(state_q);
    assign n_rx    = {byte_data, len_lo_q};

    loader_byte_fetch #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_fetch (
        .clk             (clk),
        .Rst             (Rst),
        .want            (want),
        .rx_data_present (rx_data_present),
        .uart_dout       (uart_dout),
        .tmr_clr         (sess_clr),
        .tmr_run         (tmr_run),
        .rx_ren          (rx_ren),
        .byte_vld        (byte_vld),
        .byte_data       (byte_data),
        .timeout         (timeout)
    );

    // Strobes are gated by prog so an abort cycle never issues a write or a TX push
    assign imem_prog_ena = prog && (state_q == WRITE);
    assign imem_en       = imem_prog_ena;
    assign tx_wen        = prog && (state_q == ACK) && !tx_full;
    assign uart_din      = code_q;
    assign busy          = (state_q != IDLE) && (state_q != DONE);
    assign done          = done_q;
    assign err           = err_q;

    always_comb begin
        state_d   = state_q;
        done_d    = done_q;
        err_d     = err_q;
        code_d    = code_q;
        sess_clr  = 1'b0;
        word_last = 1'b0;
        accept    = 1'b0;
        reject    = 1'b0;
        if (state_q == IDLE) begin
            if (prog && !prog_q) begin
                state_d  = SYNC;
                done_d   = 1'b0;
                err_d    = 1'b0;
                sess_clr = 1'b1;
            end
        end else if (state_q == DONE) begin
            if (!prog)
                state_d = IDLE;
        end else if (!prog) begin
            state_d = IDLE;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                SYNC: begin
                    if (byte_vld && (byte_data == LOADER_SYNC))
                        state_d = LEN0;
                end
                LEN0: begin
                    if (byte_vld)
                        state_d = LEN1;
                    else if (timeout)
                        reject = 1'b1;
                end
                LEN1: begin
                    if (byte_vld) begin
                        if ({1'b0, n_rx} > MAX_N)
                            reject = 1'b1;
                        else if (n_rx == 16'd0)
                            state_d = CSUM;
                        else
                            state_d = DATA;
                    end else if (timeout) begin
                        reject = 1'b1;
                    end
                end
                DATA: begin
                    if (byte_vld) begin
                        if (bc_q == 2'd3) begin
                            state_d   = WRITE;
                            word_last = 1'b1;
                        end
                    end else if (timeout) begin
                        reject = 1'b1;
                    end
                end
                WRITE: begin
                    state_d = ((widx_q + 16'd1) == n_q) ? CSUM : DATA;
                end
                CSUM: begin
                    if (byte_vld) begin
                        if (byte_data == xor_q)
                            accept = 1'b1;
                        else
                            reject = 1'b1;
                    end else if (timeout) begin
                        reject = 1'b1;
                    end
                end
                ACK: begin
                    if (!tx_full)
                        state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
            if (accept) begin
                state_d = ACK;
                code_d  = LOADER_ACK;
                done_d  = 1'b1;
            end
            if (reject) begin
                state_d = ACK;
                code_d  = LOADER_NAK;
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            prog_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 8'h00;
            widx_q  <= 16'd0;
            bc_q    <= 2'd0;
        end else begin
            state_q <= state_d;
            prog_q  <= prog;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
            if (sess_clr) begin
                widx_q <= 16'd0;
                bc_q   <= 2'd0;
            end else begin
                if (imem_prog_ena)
                    widx_q <= widx_q + 16'd1;
                if (byte_vld && (state_q == DATA))
                    bc_q <= bc_q + 2'd1;
            end
        end
    end

    // Word register, length and running XOR are always written before being read
    always_ff @(posedge clk) begin
        if (sess_clr)
            xor_q <= 8'h00;
        else if (byte_vld && (state_q == DATA))
            xor_q <= xor_q ^ byte_data;
        if (byte_vld && (state_q == DATA))
            word_q <= {byte_data, word_q[31:8]};
        if (byte_vld && (state_q == LEN0))
            len_lo_q <= byte_data;
        if (byte_vld && (state_q == LEN1))
            n_q <= n_rx;
    end

    // Address and data are loaded on the 4th-byte pop and then held for the WRITE cycle and beyond
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            imem_addr <= 32'h0000_0000;
            imem_din  <= 32'h0000_0000;
        end else if (word_last) begin
            imem_addr <= BASE_ADDR + {14'd0, widx_q, 2'b00};
            imem_din  <= {byte_data, word_q[31:8]};
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: directed frames push expected writes/TX bytes,
// a per-cycle monitor pops and compares whenever the DUT strobes.
module tb_uart_prog_loader;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        Rst = 1'b1;
    logic        prog = 1'b0;
    logic [7:0]  uart_dout = 8'h00;
    logic        rx_data_present = 1'b0;
    logic        rx_ren;
    logic        tx_full = 1'b0;
    logic        tx_wen;
    logic [7:0]  uart_din;
    logic        imem_prog_ena;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_din;
    logic        busy;
    logic        done;
    logic        err;

    uart_prog_loader #(
        .BASE_ADDR      (BASE),
        .MAX_WORDS      (4096),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk             (clk),
        .Rst             (Rst),
        .prog            (prog),
        .uart_dout       (uart_dout),
        .rx_data_present (rx_data_present),
        .rx_ren          (rx_ren),
        .tx_full         (tx_full),
        .tx_wen          (tx_wen),
        .uart_din        (uart_din),
        .imem_prog_ena   (imem_prog_ena),
        .imem_en         (imem_en),
        .imem_addr       (imem_addr),
        .imem_din        (imem_din),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    always #5 clk = ~clk;

    logic [7:0]  rxq[$];
    logic [63:0] wq[$];
    logic [7:0]  tq[$];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_pop = 0;
    int tx_cnt   = 0;
    int wr_cnt   = 0;
    int tx_delta = 0;

    logic [7:0] nom [11] = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                             8'hEF, 8'hBE, 8'hAD, 8'hDE};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // RX FIFO model and output monitor; inputs change at negedge, strobes sampled 1 time unit later
    always @(negedge clk) begin
        logic [63:0] w;
        logic [7:0]  t;
        rx_data_present = (rxq.size() != 0);
        uart_dout = (rxq.size() != 0) ? rxq[0] : 8'h00;
        #1;
        cyc++;
        if (!Rst) begin
            if (rx_ren || tx_wen || imem_prog_ena)
                check("strobe_excl", 32'(rx_ren) + 32'(tx_wen) + 32'(imem_prog_ena), 32'd1);
            if (rx_ren) begin
                void'(rxq.pop_front());
                last_pop = cyc;
            end
            if (imem_prog_ena) begin
                wr_cnt++;
                check("wr_latency", 32'(cyc - last_pop), 32'd1);
                check("wr_expected", 32'(wq.size() != 0), 32'd1);
                check("imem_en", 32'(imem_en), 32'd1);
                if (wq.size() != 0) begin
                    w = wq.pop_front();
                    check("wr_addr", imem_addr, w[63:32]);
                    check("wr_data", imem_din, w[31:0]);
                end
            end
            if (tx_wen) begin
                tx_cnt++;
                tx_delta = cyc - last_pop;
                check("tx_expected", 32'(tq.size() != 0), 32'd1);
                if (tq.size() != 0) begin
                    t = tq.pop_front();
                    check("tx_byte", 32'(uart_din), 32'(t));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_session();
        @(negedge clk);
        prog = 1'b0;
        tick(2);
        prog = 1'b1;
    endtask

    task automatic push_nom(input logic [7:0] cs);
        foreach (nom[i]) rxq.push_back(nom[i]);
        rxq.push_back(cs);
    endtask

    task automatic expect_nom_writes();
        wq.push_back({BASE, 32'h1234_5678});
        wq.push_back({BASE + 32'd4, 32'hDEAD_BEEF});
    endtask

    task automatic wait_tx(input string name, input int budget);
        int start = tx_cnt;
        int k = 0;
        while ((tx_cnt == start) && (k < budget)) begin
            @(negedge clk);
            #2;
            k++;
        end
        check(name, 32'(tx_cnt - start), 32'd1);
    endtask

    task automatic wait_rx_empty(input string name);
        int k = 0;
        while ((rxq.size() != 0) && (k < 200)) begin
            @(negedge clk);
            #2;
            k++;
        end
        check(name, 32'(rxq.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int w0;
        int t0;
        // Reset state
        tick(3);
        #2;
        check("rst_strobes", {28'd0, rx_ren, tx_wen, imem_prog_ena, imem_en}, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_din", imem_din, 32'd0);
        check("rst_uart_din", 32'(uart_din), 32'd0);
        check("rst_flags", {29'd0, busy, done, err}, 32'd0);
        @(negedge clk);
        Rst = 1'b0;

        // Nominal frame
        start_session();
        push_nom(8'h2A);
        expect_nom_writes();
        tq.push_back(8'h06);
        wait_tx("t1_tx", 200);
        tick(2);
        #2;
        check("t1_flags", {29'd0, busy, done, err}, 32'b010);
        check("t1_writes_done", 32'(wq.size()), 32'd0);
        @(negedge clk);
        prog = 1'b0;
        tick(3);
        #2;
        check("t1_done_hold_idle", {29'd0, busy, done, err}, 32'b010);

        // Junk before sync
        @(negedge clk);
        prog = 1'b1;
        @(negedge clk);
        #2;
        check("t2_flags_clr", {30'd0, done, err}, 32'd0);
        rxq.push_back(8'h00);
        rxq.push_back(8'hFF);
        rxq.push_back(8'h5A);
        push_nom(8'h2A);
        expect_nom_writes();
        tq.push_back(8'h06);
        wait_tx("t2_tx", 200);
        tick(2);
        #2;
        check("t2_flags", {30'd0, done, err}, 32'b10);

        // Bad checksum: writes still happen, NAK
        start_session();
        push_nom(8'h2B);
        expect_nom_writes();
        tq.push_back(8'h15);
        wait_tx("t3_tx", 200);
        tick(2);
        #2;
        check("t3_flags", {30'd0, done, err}, 32'b01);
        check("t3_writes_done", 32'(wq.size()), 32'd0);

        // Oversize length N = 4097: NAK straight after LEN1, no write
        w0 = wr_cnt;
        start_session();
        rxq.push_back(8'hA5);
        rxq.push_back(8'h01);
        rxq.push_back(8'h10);
        tq.push_back(8'h15);
        wait_tx("t4_tx", 200);
        check("t4_nak_latency", 32'(tx_delta), 32'd1);
        tick(2);
        #2;
        check("t4_flags", {30'd0, done, err}, 32'b01);
        check("t4_no_write", 32'(wr_cnt - w0), 32'd0);

        // Empty frame N = 0, checksum 00
        w0 = wr_cnt;
        start_session();
        rxq.push_back(8'hA5);
        rxq.push_back(8'h00);
        rxq.push_back(8'h00);
        rxq.push_back(8'h00);
        tq.push_back(8'h06);
        wait_tx("t5_tx", 200);
        tick(2);
        #2;
        check("t5_flags", {30'd0, done, err}, 32'b10);
        check("t5_no_write", 32'(wr_cnt - w0), 32'd0);

        // Timeout after 3 data bytes
        w0 = wr_cnt;
        start_session();
        rxq.push_back(8'hA5);
        rxq.push_back(8'h01);
        rxq.push_back(8'h00);
        rxq.push_back(8'h11);
        rxq.push_back(8'h22);
        rxq.push_back(8'h33);
        tq.push_back(8'h15);
        wait_tx("t6_tx", 400);
        check("t6_nak_delay", 32'(tx_delta), 32'd100);
        tick(2);
        #2;
        check("t6_flags", {30'd0, done, err}, 32'b01);
        check("t6_no_write", 32'(wr_cnt - w0), 32'd0);

        // Abort mid-DATA
        w0 = wr_cnt;
        start_session();
        rxq.push_back(8'hA5);
        rxq.push_back(8'h02);
        rxq.push_back(8'h00);
        rxq.push_back(8'h78);
        rxq.push_back(8'h56);
        wait_rx_empty("t7_rx_drained");
        tick(2);
        check("t7_busy_before", 32'(busy), 32'd1);
        prog = 1'b0;
        @(negedge clk);
        #2;
        check("t7_abort_idle", {29'd0, busy, done, err}, 32'd0);
        t0 = tx_cnt;
        tick(20);
        #2;
        check("t7_no_tx", 32'(tx_cnt - t0), 32'd0);
        check("t7_no_write", 32'(wr_cnt - w0), 32'd0);

        // TX backpressure in ACK
        @(negedge clk);
        tx_full = 1'b1;
        start_session();
        push_nom(8'h2A);
        expect_nom_writes();
        tq.push_back(8'h06);
        wait_rx_empty("t8_rx_drained");
        t0 = tx_cnt;
        tick(50);
        #2;
        check("t8_tx_held", 32'(tx_cnt - t0), 32'd0);
        check("t8_busy_in_ack", 32'(busy), 32'd1);
        @(negedge clk);
        tx_full = 1'b0;
        wait_tx("t8_tx", 50);
        tick(20);
        #2;
        check("t8_tx_once", 32'(tx_cnt - t0), 32'd1);
        check("t8_flags", {29'd0, busy, done, err}, 32'b010);

        @(negedge clk);
        prog = 1'b0;
        tick(5);
        #2;
        check("final_wq_empty", 32'(wq.size()), 32'd0);
        check("final_tq_empty", 32'(tq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

Serial program loader between the UART controller's receive/transmit FIFO ports and the memory controller's instruction-memory programming port. While `prog` is high it parses a framed byte stream from the UART, assembles little-endian 32-bit words, and writes them sequentially into instruction memory. It then verifies an XOR checksum and answers ACK or NAK over UART transmit. This lets the core be reprogrammed without re-synthesis.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: imem byte address of word 0.
- `MAX_WORDS`, default 4096: largest accepted word count.
- `TIMEOUT_CYCLES`, default 50_000_000: inter-byte timeout, 1 s at 50 MHz.

Ports. Clock is `clk`; reset is `Rst`, asynchronous and active-high.
- `clk` in 1: system clock (50 MHz domain).
- `Rst` in 1: async active-high reset.
- `prog` in 1: loader enable, level.
- `uart_dout` in 8: head byte of the UART RX FIFO; valid while `rx_data_present`.
- `rx_data_present` in 1: RX FIFO non-empty.
- `rx_ren` out 1: RX pop strobe.
- `tx_full` in 1: TX FIFO full.
- `tx_wen` out 1: TX push strobe.
- `uart_din` out 8: TX byte.
- `imem_prog_ena` out 1: imem write strobe.
- `imem_en` out 1: imem enable.
- `imem_addr` out 32: imem byte address.
- `imem_din` out 32: imem write word.
- `busy` out 1: frame in progress.
- `done` out 1: frame accepted.
- `err` out 1: frame rejected.

## Operation
- Frame layout, in order:
  - sync byte 8'hA5
  - `N[7:0]`, then `N[15:8]`
  - N×4 data bytes, each word LSB first
  - checksum = XOR of all data bytes
- States: IDLE, SYNC, LEN0, LEN1, DATA, WRITE, CSUM, ACK, DONE.
- IDLE → SYNC on `prog` rising edge. Entering SYNC clears `done`/`err`, word index, running XOR and timer.
- SYNC: pops and discards bytes until 8'hA5, then → LEN0. No timeout applies in SYNC.
- LEN0 → LEN1 → decide on the length:
  - N > MAX_WORDS: set `err`, → ACK with NAK.
  - N = 0: → CSUM.
  - Otherwise: → DATA.
- DATA: shifts bytes into the word register. The 4th byte → WRITE.
- WRITE, one cycle:
  - `imem_prog_ena`=`imem_en`=1.
  - `imem_addr` = BASE_ADDR + 4·i, computed mod 2^32.
  - `imem_din` = assembled word.
  - Then i+1. If i+1 = N → CSUM, else → DATA.
- CSUM: if received byte equals the running XOR → ACK with 8'h06 and `done`=1. Otherwise → ACK with 8'h15 and `err`=1. Words already written are not rolled back.
- ACK: waits while `tx_full`. Then pulses `tx_wen` for one cycle with `uart_din` = ACK/NAK code, → DONE.
- DONE: holds `done`/`err` until `prog` falls → IDLE. `done`/`err` persist in IDLE until the next session.
- Timeout: a counter resets on each popped byte and runs in LEN0..CSUM. Reaching TIMEOUT_CYCLES sets `err` and → ACK with NAK.
- `prog` falling in any state other than DONE or IDLE: abort to IDLE on the next edge.
  - Sets no flags.
  - Sends no ACK/NAK.
  - Any in-flight `tx_wen`/`imem_prog_ena` strobe is not issued.
- `busy` = 1 in SYNC through ACK.

## Timing
- Reset values: all outputs 0; state IDLE.
- Byte fetch:
  - `rx_ren` rises for one cycle when the state expects a byte, `rx_data_present`=1, and `rx_ren` was 0 in the previous cycle.
  - `uart_dout` is sampled in that same cycle.
  - Back-to-back pops are forbidden; peak rate is 1 byte per 2 cycles.
- Write latency: `imem_prog_ena` asserts exactly 1 cycle after the cycle that pops the 4th byte of a word.
- Strobes `rx_ren`, `tx_wen` and `imem_prog_ena` are never asserted together.
- A byte popped in CSUM is compared in the same cycle. The ACK state is entered on the next edge.
- `imem_addr`/`imem_din` hold their last values outside WRITE.

## Structure
- Package `rv_loader_pkg` contains:
  - the `loader_state_t` enum;
  - `LOADER_SYNC` = 8'hA5, `LOADER_ACK` = 8'h06, `LOADER_NAK` = 8'h15.
- Sub-module `loader_byte_fetch` owns:
  - the `rx_ren` pacing;
  - the byte-valid pulse and byte capture;
  - the timeout counter.
- The main FSM, word assembly, address generation and XOR live in `uart_prog_loader`.

## Test plan
- **Nominal frame:** `prog`=1, feed A5 02 00 78 56 34 12 EF BE AD DE, checksum byte = XOR of the 8 data bytes.
  - Writes 32'h12345678 at BASE, then 32'hDEADBEEF at BASE+4.
  - TX 8'h06, `done`=1.
- **Junk before sync:** 00 FF 5A, then the nominal frame → junk discarded, identical result.
- **Bad checksum:** nominal frame with checksum XOR 8'h01.
  - Both writes still occur.
  - TX 8'h15, `err`=1, `done`=0.
- **Oversize or empty length:**
  - N = MAX_WORDS+1 → no write, NAK immediately after LEN1.
  - N = 0 with checksum 00 → ACK, no write.
- **Timeout:** with TIMEOUT_CYCLES=100, stop after 3 data bytes.
  - NAK 100 cycles after the last pop; no write.
- **Abort and backpressure:**
  - Drop `prog` mid-DATA → IDLE next cycle, no TX, flags 0.
  - Hold `tx_full`=1 for 50 cycles in ACK → `tx_wen` is delayed until release and pulses exactly once.
